// File: rtl/alu_mdstep_seq.sv
// Iterative unsigned 32x32 multiply / 32/32 restoring divide sequencer.
// Borrows the shared 33-bit ALU slice chain for one step per cycle.
module alu_mdstep_seq #(
  parameter int unsigned STEPS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] opnd_x,
  input  logic [31:0] opnd_y,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        alu_own,
  output logic [31:0] alu_m,
  output logic [31:0] alu_a,
  output logic [3:0]  aluf,
  output logic        alumode,
  output logic        cin0,
  input  logic [32:0] alu
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  localparam logic [3:0] F_PASS_M = 4'b0000;
  localparam logic [3:0] F_ADD    = 4'b1001;
  localparam logic [3:0] F_SUB    = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [W-1:0]     p_q, p_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d, div_zero_d;
  logic [W-1:0]     result_lo_d, result_hi_d;
  logic [W-1:0]     rem;
  logic             cy;

  assign alu_own = busy;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      p_q       <= p_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
      result_lo <= result_lo_d;
      result_hi <= result_hi_d;
    end
  end

  // Next-state, step datapath and ALU drive
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    div_zero_d  = div_zero;
    result_lo_d = result_lo;
    result_hi_d = result_hi;
    alu_m       = '0;
    alu_a       = '0;
    aluf        = F_PASS_M;
    alumode     = 1'b0;
    cin0        = 1'b0;
    rem         = {p_q[W-2:0], q_q[W-1]};
    cy          = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d       = op;
          p_d        = '0;
          q_d        = opnd_x;
          d_d        = opnd_y;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          if (op && (opnd_y == '0)) begin
            state_d     = DONE;
            done_d      = 1'b1;
            div_zero_d  = 1'b1;
            result_lo_d = '1;
            result_hi_d = opnd_x;
          end else begin
            state_d = STEP;
            busy_d  = 1'b1;
          end
        end
      end

      STEP: begin
        alu_a = d_q;
        if (!op_q) begin
          // Shift-add multiply; a pass-through step carries nothing out
          alu_m = p_q;
          aluf  = q_q[0] ? F_ADD : F_PASS_M;
          cy    = q_q[0] & (alu[W] ^ alu_m[W-1] ^ alu_a[W-1]);
          p_d   = {cy, alu[W-1:1]};
          q_d   = {alu[0], q_q[W-1:1]};
        end else begin
          // Restoring divide: keep the difference only when no borrow
          alu_m = rem;
          aluf  = F_SUB;
          cin0  = 1'b1;
          cy    = alu[W] ^ alu_m[W-1] ^ ~alu_a[W-1];
          p_d   = cy ? alu[W-1:0] : rem;
          q_d   = {q_q[W-2:0], cy};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d     = DONE;
          done_d      = 1'b1;
          result_hi_d = p_d;
          result_lo_d = q_d;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mdstep_seq.sv
// Scoreboard bench for alu_mdstep_seq with a behavioural 74S181-style ALU
// model closing the loop on the sequencer's operand and function drive.
`timescale 1ns/1ps
module tb_alu_mdstep_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] opnd_x;
  logic [31:0] opnd_y;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        alu_own;
  logic [31:0] alu_m;
  logic [31:0] alu_a;
  logic [3:0]  aluf;
  logic        alumode;
  logic        cin0;
  logic [32:0] alu;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_mdstep_seq #(.STEPS(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .opnd_x    (opnd_x),
    .opnd_y    (opnd_y),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .alu_own   (alu_own),
    .alu_m     (alu_m),
    .alu_a     (alu_a),
    .aluf      (aluf),
    .alumode   (alumode),
    .cin0      (cin0),
    .alu       (alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic-mode slice chain: M plus A, M minus A minus 1, or M, plus carry-in
  always_comb begin
    case (aluf)
      4'b1001: alu = {alu_m[31], alu_m} + {alu_a[31], alu_a} + 33'(cin0);
      4'b0110: alu = {alu_m[31], alu_m} + {~alu_a[31], ~alu_a} + 33'(cin0);
      default: alu = {alu_m[31], alu_m} + 33'(cin0);
    endcase
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] prod;
    if (!o) begin
      prod = 64'(x) * 64'(y);
      e.lo = prod[31:0];
      e.hi = prod[63:32];
      e.dz = 1'b0;
    end else if (y == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = x;
      e.dz = 1'b1;
    end else begin
      e.lo = x / y;
      e.hi = x % y;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Results are compared against the scoreboard whenever done pulses
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_lo", 64'(result_lo), 64'(e.lo));
        check("result_hi", 64'(result_hi), 64'(e.hi));
        check("div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  // One operation; in_done means we are already at the negedge of a DONE cycle
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input int glitch, input bit in_done);
    exp_t e;
    int   cyc;
    bit   seen;
    logic exp_b;
    e = model(o, x, y);
    sb.push_back(e);
    if (!in_done) @(negedge clk);
    start  = 1'b1;
    op     = o;
    opnd_x = x;
    opnd_y = y;
    @(negedge clk);
    start  = 1'b0;
    op     = ~o;
    opnd_x = $urandom;
    opnd_y = $urandom;
    cyc    = 1;
    seen   = 1'b0;
    while (!seen && cyc <= 40) begin
      exp_b = !e.dz && (cyc <= 32);
      check("busy", 64'(busy), 64'(exp_b));
      check("alu_own", 64'(alu_own), 64'(exp_b));
      if (!exp_b) check("alu_m_idle", 64'(alu_m), 64'd0);
      if (done) begin
        seen = 1'b1;
        check("done_cycle", 64'(cyc), e.dz ? 64'd1 : 64'd33);
      end else begin
        start = (cyc == glitch);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 1'b0;
    opnd_x  = '0;
    opnd_y  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_result_lo", 64'(result_lo), 64'd0);
    check("rst_result_hi", 64'(result_hi), 64'd0);
    check("rst_alu_own", 64'(alu_own), 64'd0);
    check("rst_aluf", 64'(aluf), 64'd0);
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("idle_no_done", 64'(dones), 64'd0);

    run_op(1'b0, 32'd7, 32'd6, -1, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, -1, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, -1, 1'b0);
    run_op(1'b1, 32'h1234_5678, 32'd0, -1, 1'b0);
    repeat (3) @(negedge clk);
    check("div_zero_hold", 64'(div_zero), 64'd1);
    check("result_hold", 64'(result_hi), 64'h1234_5678);

    // start pulse mid-operation must be ignored
    run_op(1'b0, 32'h0001_2345, 32'h8765_4321, 10, 1'b0);
    // start during the DONE cycle is accepted immediately
    run_op(1'b1, 32'd1000, 32'd3, -1, 1'b1);
    run_op(1'b0, 32'hA5A5_0F0F, 32'hC000_0001, -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic        o;
      logic [31:0] x;
      logic [31:0] y;
      o = i[0];
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (i == 2) y = y | 32'h8000_0000;
      run_op(o, x, y, -1, 1'b0);
    end

    // Reset mid-operation aborts with no done
    @(negedge clk);
    start  = 1'b1;
    op     = 1'b0;
    opnd_x = 32'd9;
    opnd_y = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_alu_own", 64'(alu_own), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result_lo", 64'(result_lo), 64'd0);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdstep_seq.md
Name: alu_mdstep_seq

Overview:
- Iterative unsigned multiply/divide sequencer. It owns the shared 33-bit ALU slice chain for 32 step cycles per operation.
- It drives the ALU operands, function select, mode and carry-in, and consumes the combinational alu[32:0] result in the same cycle.
- It holds the partial product or remainder and the shifting Q register internally.
- The main datapath mux selects the sequencer's drive while alu_own is high.

Parameters:
STEPS, 32, number of step cycles per operation; equals the ALU width.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
start  in  1  request; sampled only in IDLE or DONE
op  in  1  0 = multiply, 1 = divide
opnd_x  in  32  multiplier or dividend
opnd_y  in  32  multiplicand or divisor
busy  out  1  high during STEP cycles
done  out  1  one-cycle pulse when results become valid
div_zero  out  1  last divide had divisor 0; held until next accepted start
result_lo  out  32  product[31:0] or quotient
result_hi  out  32  product[63:32] or remainder
alu_own  out  1  high while the sequencer drives the ALU
alu_m  out  32  ALU M operand (74S181 A input)
alu_a  out  32  ALU A operand (74S181 B input)
aluf  out  4  74S181 S select
alumode  out  1  74S181 M (0 = arithmetic)
cin0  out  1  carry into bit 0, active high
alu  in  33  ALU result; bit 32 is the sign-extended sum bit

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, on reset_n.
- Reset (reset_n = 0 at a clk edge):
  - State goes to IDLE.
  - busy, done, div_zero, alu_own = 0.
  - result_lo, result_hi = 0.
  - Internal P, Q, D registers = 0.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, STEP, DONE. DONE lasts one cycle, then returns to IDLE. A start in DONE is accepted exactly as in IDLE.
- Accept (start = 1 in IDLE or DONE):
  - Load P = 0, Q = opnd_x, D = opnd_y, step count = 0; clear div_zero.
  - Go to STEP.
  - Exception: op = 1 and opnd_y = 0. Go directly to DONE with result_lo = 32'hFFFFFFFF, result_hi = opnd_x, div_zero = 1.
- STEP (busy = 1, alu_own = 1, alumode = 0); the result is consumed combinationally in the same cycle:
  - Multiply:
    - alu_m = P, alu_a = D.
    - If Q[0] = 1: aluf = 4'b1001, cin0 = 0 (add). Otherwise: aluf = 4'b0000, cin0 = 0 (pass M).
    - Unsigned carry cy = alu[32] ^ alu_m[31] ^ alu_a[31].
    - Next: P = {cy, alu[31:1]}, Q = {alu[0], Q[31:1]}.
  - Divide (restoring):
    - Let R = {P[30:0], Q[31]}.
    - Drive alu_m = R, alu_a = D, aluf = 4'b0110, cin0 = 1 (subtract).
    - No-borrow cy = alu[32] ^ alu_m[31] ^ ~alu_a[31].
    - If cy = 1: P = alu[31:0], Q = {Q[30:0], 1}. Otherwise: P = R, Q = {Q[30:0], 0}.
    - With a 32-bit dividend, R never exceeds 32 bits, so no extra remainder bit is kept.
- Step count increments every STEP cycle. After the STEPS-th step, go to DONE.
- DONE: done = 1 for one cycle; busy = 0; result_hi = P, result_lo = Q, registered at DONE entry.
- Results and div_zero hold until the next accepted start.
- When not in STEP: alu_own = 0, alu_m = 0, alu_a = 0, aluf = 0, alumode = 0, cin0 = 0.
- Latency:
  - start accepted at edge 0; busy high for cycles 1..32; done in cycle 33.
  - Divide by zero: done in cycle 1, with busy never asserted.
- start while in STEP: ignored. Neither queued nor restarted.
- op, opnd_x, opnd_y are sampled only at accept; changes during STEP have no effect.

Test Plan:
- Reset then idle: hold reset_n = 0 for 2 cycles, release -> all outputs 0, alu_own = 0, no done for 50 cycles.
- Multiply small: op = 0, x = 7, y = 6 -> busy high for exactly 32 cycles; done in cycle 33; hi = 0, lo = 32'h0000002A.
- Multiply max: x = y = 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 32'h00000001, which exercises the cy path.
- Divide: op = 1, x = 100, y = 7 -> lo = 14, hi = 2, div_zero = 0.
- Divide edge cases:
  - x = 32'hFFFFFFFF, y = 32'h80000000 -> lo = 1, hi = 32'h7FFFFFFF.
  - y = 0, x = 32'h12345678 -> done in cycle 1, lo = 32'hFFFFFFFF, hi = 32'h12345678, div_zero = 1.
- Control hazards:
  - Pulse start at step 10 -> ignored; results unaffected.
  - Assert reset_n = 0 at step 20 -> no done; IDLE next cycle; alu_own = 0.
  - start in the DONE cycle -> new operation accepted, busy the next cycle.
